briey_program_loader: RTL

BRIEY_PROGRAM_LOADER -- requirements
Module: briey_program_loader

---
 rtl/briey_program_loader_if.sv | 49 ++++
 rtl/briey_program_loader.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/briey_program_loader_if.sv
// Bus bundle for the Briey program loader: input word stream plus the
// AW/W/B channels of the RAM reload port.
interface briey_program_loader_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int LINE_WIDTH = 512,
  parameter int WORD_WIDTH = 32
);
  logic                      s_valid;
  logic                      s_ready;
  logic [WORD_WIDTH-1:0]     s_data;
  logic                      s_last;

  logic                      aw_valid;
  logic                      aw_ready;
  logic [ADDR_WIDTH-1:0]     aw_addr;

  logic                      w_valid;
  logic                      w_ready;
  logic [LINE_WIDTH-1:0]     w_data;
  logic [LINE_WIDTH/8-1:0]   w_strb;
  logic                      w_last;

  logic                      b_valid;
  logic                      b_ready;
  logic [1:0]                b_resp;

  // The loader drives the RAM side and consumes the word stream.
  modport master (
    input  s_valid, s_data, s_last,
    output s_ready,
    output aw_valid, aw_addr,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_resp,
    output b_ready
  );

  modport slave (
    output s_valid, s_data, s_last,
    input  s_ready,
    input  aw_valid, aw_addr,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_resp,
    input  b_ready
  );
endinterface

// File: rtl/briey_program_loader.sv
// Packs a stream of program words into RAM lines and writes each line to the
// Briey RAM reload port, one AW/W/B transaction per line.
module briey_program_loader #(
  parameter int ADDR_WIDTH = 15,
  parameter int LINE_WIDTH = 512,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  briey_program_loader_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           lines_written
);

  localparam int STRB_WIDTH = LINE_WIDTH / 8;
  localparam int WORDS      = LINE_WIDTH / WORD_WIDTH;
  localparam int WORD_BYTES = WORD_WIDTH / 8;
  localparam int IDX_WIDTH  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LINE_BYTES = ADDR_WIDTH'(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = ~ADDR_WIDTH'(STRB_WIDTH - 1);
  localparam logic [IDX_WIDTH-1:0]  LAST_IDX   = IDX_WIDTH'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ISSUE,
    RESP,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LINE_WIDTH-1:0]   buf_q, buf_d;
  logic [STRB_WIDTH-1:0]   strb_q, strb_d;
  logic [IDX_WIDTH-1:0]    idx_q, idx_d;
  logic                    last_q, last_d;
  logic                    aw_pend_q, aw_pend_d;
  logic                    w_pend_q, w_pend_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic [15:0]             lines_q, lines_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      buf_q     <= '0;
      strb_q    <= '0;
      idx_q     <= '0;
      last_q    <= 1'b0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      lines_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      buf_q     <= buf_d;
      strb_q    <= strb_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      done_q    <= done_d;
      error_q   <= error_d;
      lines_q   <= lines_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    buf_d     = buf_q;
    strb_d    = strb_q;
    idx_d     = idx_q;
    last_d    = last_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    done_d    = done_q;
    error_d   = error_q;
    lines_d   = lines_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base_addr & LINE_MASK;
          buf_d   = '0;
          strb_d  = '0;
          idx_d   = '0;
          last_d  = 1'b0;
          done_d  = 1'b0;
          error_d = 1'b0;
          lines_d = '0;
          state_d = FILL;
        end
      end

      FILL: begin
        if (bus.s_valid) begin
          buf_d[WORD_WIDTH*idx_q +: WORD_WIDTH] = bus.s_data;
          strb_d[WORD_BYTES*idx_q +: WORD_BYTES] = '1;
          idx_d = idx_q + 1'b1;
          // A line closes on its last slot or on the end of the program.
          if (bus.s_last || (idx_q == LAST_IDX)) begin
            last_d    = bus.s_last;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = ISSUE;
          end
        end
      end

      ISSUE: begin
        aw_pend_d = aw_pend_q && !bus.aw_ready;
        w_pend_d  = w_pend_q && !bus.w_ready;
        if (!aw_pend_d && !w_pend_d) begin
          state_d = RESP;
        end
      end

      RESP: begin
        if (bus.b_valid) begin
          lines_d = lines_q + 16'd1;
          if (bus.b_resp != 2'b00) begin
            error_d = 1'b1;
          end
          if (last_q) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + LINE_BYTES;
            buf_d   = '0;
            strb_d  = '0;
            idx_d   = '0;
            state_d = FILL;
          end
        end
      end

      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.s_ready  = (state_q == FILL);
  assign bus.aw_valid = aw_pend_q;
  assign bus.aw_addr  = addr_q;
  assign bus.w_valid  = w_pend_q;
  assign bus.w_data   = buf_q;
  assign bus.w_strb   = strb_q;
  assign bus.w_last   = 1'b1;
  assign bus.b_ready  = (state_q == RESP);

  assign busy          = (state_q == FILL) || (state_q == ISSUE) || (state_q == RESP);
  assign done          = done_q;
  assign error         = error_q;
  assign lines_written = lines_q;

endmodule
